// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: elastic FIFO of {pc, npc, instr} entries between
// instruction fetch and decode, with valid/ready handshakes on both sides
// and a single-cycle flush for branch/jump redirects.
// Optional feature macro: FD_BUFFER_PERF_EN enables the stall/flush
// performance counters; without it both counter ports read zero.
module fetch_decode_buffer #(
  parameter int                XLEN      = 32,
  parameter int                DEPTH     = 2,
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_npc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_npc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Storage is deliberately not reset; occupancy alone says what is valid.
  logic [XLEN-1:0]  r_mem_pc    [DEPTH];
  logic [XLEN-1:0]  r_mem_npc   [DEPTH];
  logic [XLEN-1:0]  r_mem_instr [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Ready depends only on registered occupancy, so a full buffer refuses a
  // push even when decode pops in the same cycle.
  assign w_in_ready  = (r_count < CNT_FULL);
  assign w_out_valid = (r_count != '0);

  // Flush dominates: the offered entry is dropped and no pop is taken.
  assign w_push = in_valid && w_in_ready && !flush_i;
  assign w_pop  = w_out_valid && out_ready && !flush_i;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;

  // Head entry is shown only while valid; otherwise decode sees a NOP.
  assign out_pc    = w_out_valid ? r_mem_pc[r_rd_ptr]    : '0;
  assign out_npc   = w_out_valid ? r_mem_npc[r_rd_ptr]   : '0;
  assign out_instr = w_out_valid ? r_mem_instr[r_rd_ptr] : NOP_INSTR;

  // Pointer and occupancy update; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // One write port per entry slot, selected by the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the fetched entry into this slot on an accepted push.
    always_ff @(posedge clk) begin
      if (rst_n && w_push && (r_wr_ptr == PTR_W'(gi))) begin
        r_mem_pc[gi]    <= in_pc;
        r_mem_npc[gi]   <= in_npc;
        r_mem_instr[gi] <= in_instr;
      end
    end
  end

`ifdef FD_BUFFER_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Count decode back-pressure cycles and flushes that discard real work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_out_valid && !out_ready && !flush_i)
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (flush_i && w_out_valid)
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer (DEPTH=2).
module tb_fetch_decode_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_npc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic [31:0] out_instr;
  logic [1:0]  count;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_decode_buffer #(.XLEN(32), .DEPTH(2), .NOP_INSTR(32'h00000013)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_npc         (in_npc),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_npc        (out_npc),
    .out_instr      (out_instr),
    .count          (count),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_npc   = pc + 32'd4;
    in_instr = instr;
  endtask

  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_npc = '0; in_instr = '0;
    tick(); tick();
    rst_n = 1'b1;

    // 1. Reset after filling
    offer(32'h10, 32'h11111113); tick();
    offer(32'h14, 32'h22222213); tick();
    in_valid = 1'b0;
    check("fill_count", 32'(count), 32'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr,      32'h00000013);
    check("rst_out_pc",    out_pc,         32'h0);
    check("rst_out_npc",   out_npc,        32'h0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // 2. Single pass
    out_ready = 1'b1;
    offer(32'h0, 32'h00000093);
    check("empty_no_fallthrough", 32'(out_valid), 32'd0);
    tick(); in_valid = 1'b0;
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_pc",    out_pc,         32'h0);
    check("pass_npc",   out_npc,        32'h4);
    check("pass_instr", out_instr,      32'h00000093);
    tick();
    check("pass_consumed", 32'(out_valid), 32'd0);

    // 3. Fill and stall
    out_ready = 1'b0;
    offer(32'h0, 32'h00000093); tick();
    offer(32'h4, 32'h00500113); tick();
    offer(32'h8, 32'h00310233);
    out_ready = 1'b1;  // full: push refused even with simultaneous pop
    check("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    check("full_count", 32'(count),    32'd2);
    check("full_hold_pc", out_pc,      32'h0);
    out_ready = 1'b1;
    tick();
    check("drain1_pc",    out_pc,    32'h4);
    check("drain1_instr", out_instr, 32'h00500113);
    tick();
    check("drain_empty_count", 32'(count), 32'd0);
    check("third_not_taken",   32'(out_valid), 32'd0);

    // 4. Concurrent push/pop with pointer wrap
    out_ready = 1'b0;
    offer(32'h0, 32'h00001000); tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      offer(32'(4 * i), 32'h00001000 + 32'(i));
      tick();
      check($sformatf("pp%0d_count", i), 32'(count), 32'd1);
      check($sformatf("pp%0d_pc", i),    out_pc,     32'(4 * i));
      check($sformatf("pp%0d_instr", i), out_instr,  32'h00001000 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("pp_drain_count", 32'(count), 32'd0);

    // 5. Flush priority
    out_ready = 1'b0;
    offer(32'h200, 32'h00000093); tick();
    offer(32'h204, 32'h00000093); tick();
    check("pre_flush_count", 32'(count), 32'd2);
    flush_i = 1'b1; out_ready = 1'b1; offer(32'h100, 32'h0000DEAD);
    tick();
    flush_i = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(count),     32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_pc",    out_pc,         32'h0);
    tick();
    check("flush_no_late_pc", out_pc, 32'h0);
    // Flush with room to push: push must still be dropped
    out_ready = 1'b0;
    offer(32'h300, 32'h00000093); tick();
    flush_i = 1'b1; offer(32'h100, 32'h0000DEAD);
    tick();
    flush_i = 1'b0; in_valid = 1'b0;
    check("flush1_count", 32'(count), 32'd0);
    tick();
    check("flush1_no_pc100", 32'(out_valid), 32'd0);

    // 6. Perf counters
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("perf_rst_stall", perf_stall_cnt, 32'd0);
    check("perf_rst_flush", perf_flush_cnt, 32'd0);
    out_ready = 1'b0;
    offer(32'h40, 32'h00000093); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush_i = 1'b1; tick();
    tick();  // flush of an empty buffer is not counted
    flush_i = 1'b0;
`ifdef FD_BUFFER_PERF_EN
    exp_stall = 32'd5;
    exp_flush = 32'd1;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    check("perf_stall", perf_stall_cnt, exp_stall);
    check("perf_flush", perf_flush_cnt, exp_flush);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Elastic buffer between instruction_fetch and the decode stage.
- Holds up to DEPTH fetched {pc, npc, instruction} entries in FIFO order, using valid/ready handshakes on both sides.
- Lets fetch keep running while decode stalls.
- A branch/jump flush discards all buffered entries in one cycle.

Parameters:
- XLEN, 32, width of pc/npc/instruction.
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, value driven on out_instr when the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush_i  input  1  discard all entries (taken branch/jump redirect).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  buffer can accept an entry.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_npc  input  XLEN  next PC (pc+4).
- in_instr  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  XLEN  head PC.
- out_npc  output  XLEN  head NPC.
- out_instr  output  XLEN  head instruction.
- count  output  $clog2(DEPTH)+1  current occupancy.
- perf_stall_cnt  output  32  see Optional Feature.
- perf_flush_cnt  output  32  see Optional Feature.

Behaviour:
- Reset is synchronous on rst_n==0 at the clk edge. After reset:
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_pc=0, out_npc=0, out_instr=NOP_INSTR.
  - perf counters=0.
  - Storage array is not reset.
- Reset mid-operation discards all entries exactly like flush.
- Push occurs when in_valid && in_ready at the edge: entry written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready at the edge: rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH).
  - Derived from registered count only; no combinational path from out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_pc/out_npc/out_instr = entry[rd_ptr] when out_valid; 0/0/NOP_INSTR otherwise.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no fall-through of in_* to out_* in the same cycle.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle (possible when 0 < count < DEPTH): count unchanged, both pointers advance.
  - Empty with in_valid: push only; out_valid stays 0 until the next cycle.
- Flush:
  - flush_i=1 at an edge sets wr_ptr=rd_ptr=0 and count=0.
  - Flush has priority over push and pop in the same cycle. The offered input entry is dropped and no pop is counted.
  - Outputs show the empty values on the next cycle.
- Pointers wrap from DEPTH-1 to 0. Pointer width is $clog2(DEPTH); count is one bit wider so it can hold DEPTH.
- Inputs are not checked for X; in_* contents are ignored when in_valid=0.

Optional Feature:
- Macro FD_BUFFER_PERF_EN.
- When defined:
  - perf_stall_cnt increments each cycle with out_valid && !out_ready && !flush_i.
  - perf_flush_cnt increments each cycle with flush_i=1 and count!=0.
  - Both counters are 32-bit, wrap from 32'hFFFFFFFF to 0, and are cleared only by reset.
- When undefined: both ports exist but are tied to 32'h0, and no counter flops are synthesized.

Test Plan:
1. Reset:
   - Stimulus: push 2 entries, then rst_n=0 for 1 edge.
   - Required: count=0, out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1.
2. Single pass:
   - Stimulus: out_ready=1; push pc=0, npc=4, instr=32'h00000093.
   - Required: next cycle out_valid=1, out_pc=0, out_npc=4, out_instr=32'h00000093. The following cycle out_valid=0 (entry consumed).
3. Fill and stall:
   - Stimulus: out_ready=0; push pc=0/instr=32'h00000093, pc=4/instr=32'h00500113, then offer pc=8/instr=32'h00310233.
   - Required: count=2, in_ready=0, third entry not accepted, out_pc=0 held.
   - Then out_ready=1: out_pc=0 then 4 in consecutive cycles.
4. Concurrent push/pop:
   - Stimulus: count=1 with in_valid=1, out_ready=1 for 6 cycles, pcs 0,4,8,...
   - Required: count stays 1, outputs appear in order with 1-cycle lag, and pointer wrap is exercised.
5. Flush priority:
   - Stimulus: count=2; flush_i=1 together with in_valid=1 (pc=32'h100) and out_ready=1.
   - Required: next cycle count=0, out_valid=0. pc=32'h100 never appears on the outputs.
6. Perf (FD_BUFFER_PERF_EN defined):
   - Stimulus: hold out_valid=1 with out_ready=0 for 5 cycles, then flush a non-empty buffer.
   - Required: perf_stall_cnt=5, perf_flush_cnt=1.
   - Without the macro both read 0.
